wr_arb_ctrl: RTL and testbench

WR_ARB_CTRL -- requirements
Module: wr_arb_ctrl

---
 rtl/wr_arb_ctrl.sv | 115 +++++++++++
 tb/tb_wr_arb_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/wr_arb_ctrl.sv
// wr_arb_ctrl: round-robin arbiter feeding one FIFO write port.
// A two-state FSM (IDLE/WRITE) caps throughput at one write per two cycles.
// This gives the FIFO full flag time to reflect the previous write before the next grant.
// Optional feature: define WR_ARB_OVF_CNT_EN to add a saturating 16-bit overflow counter (ovf_cnt).
`ifndef WIDTH
`define WIDTH 8
`endif

module wr_arb_ctrl #(
  parameter int NUM_REQ = 4
) (
  input  logic                       wr_clk,
  input  logic                       res,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*`WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic                       full,
  input  logic                       overflow,
  output logic                       wr_en,
  output logic [`WIDTH-1:0]          wdata
`ifdef WR_ARB_OVF_CNT_EN
  ,
  output logic [15:0]                ovf_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    last_gnt_q;
  logic                wr_en_q;
  logic [`WIDTH-1:0]   wdata_q;

  logic [IDX_W-1:0]    gnt_idx_d;
  logic                found_d;
  logic                grant_fire;
  logic [IDX_W-1:0]    cand;

  // Round-robin search: first active requester after last_gnt, wrapping.
  always_comb begin
    gnt_idx_d = last_gnt_q;
    found_d   = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_gnt_q) + k) % NUM_REQ);
      if (!found_d && req[cand]) begin
        found_d   = 1'b1;
        gnt_idx_d = cand;
      end
    end
  end

  // A grant fires only from IDLE, with room in the FIFO and reset released.
  assign grant_fire = (state_q == IDLE) && !full && found_d && !res;
  assign gnt        = grant_fire ? (NUM_REQ'(1) << gnt_idx_d) : '0;

  // FSM with registered write enable and data; wdata holds between writes.
  always_ff @(posedge wr_clk) begin
    if (res) begin
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      wdata_q    <= '0;
      last_gnt_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_fire) begin
            state_q    <= WRITE;
            wr_en_q    <= 1'b1;
            wdata_q    <= req_data[int'(gnt_idx_d)*`WIDTH +: `WIDTH];
            last_gnt_q <= gnt_idx_d;
          end else begin
            wr_en_q    <= 1'b0;
          end
        end
        WRITE: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en = wr_en_q;
  assign wdata = wdata_q;

`ifdef WR_ARB_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  // Count overflow cycles, sticking at all-ones.
  always_ff @(posedge wr_clk) begin
    if (res) begin
      ovf_cnt_q <= '0;
    end else if (overflow && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  // Overflow has no consumer when the counter is compiled out.
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

endmodule

// File: tb/tb_wr_arb_ctrl.sv
// Directed, table-driven bench for wr_arb_ctrl (NUM_REQ=4, 8-bit data).
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_wr_arb_ctrl;

  logic        wr_clk = 1'b0;
  logic        res;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        full;
  logic        overflow;
  logic        wr_en;
  logic [7:0]  wdata;
`ifdef WR_ARB_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  wr_arb_ctrl #(.NUM_REQ(4)) dut (
    .wr_clk   (wr_clk),
    .res      (res),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .full     (full),
    .overflow (overflow),
    .wr_en    (wr_en),
    .wdata    (wdata)
`ifdef WR_ARB_OVF_CNT_EN
    ,
    .ovf_cnt  (ovf_cnt)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic       res;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic       wr_en;
    logic [7:0] wdata;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic f,
                     input logic [3:0] g, input logic we, input logic [7:0] wd);
    vec_t v;
    v.res = r; v.req = rq; v.full = f; v.gnt = g; v.wr_en = we; v.wdata = wd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  initial begin
    int wr_count;
    // Slice i of req_data belongs to requester i.
    req_data = {8'h3C, 8'hA5, 8'h11, 8'h5A};
    res = 1'b1; req = 4'b0000; full = 1'b0; overflow = 1'b0;

    //  res   req     full  gnt     wr_en wdata
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00); // 0  reset: no grant, outputs cleared
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 8'h00); // 1  requester 0 first
    add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h5A); // 2  WRITE
    add(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0, 8'h5A); // 3
    add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11); // 4
    add(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0, 8'h11); // 5
    add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA5); // 6
    add(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0, 8'hA5); // 7
    add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h3C); // 8
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 8'h3C); // 9  wraps to 0
    add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h5A); // 10 last=0
    for (int i = 0; i < 5; i++)
      add(1'b0, 4'b0011, 1'b1, 4'b0000, 1'b0, 8'h5A); // 11-15 full: hold everything
    add(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b0, 8'h5A); // 16 successor of 0 is 1
    add(1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 8'h11); // 17 last=1
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, 8'h11); // 18 single requester 2
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA5); // 19
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5); // 20 back in IDLE, wdata held
    add(1'b0, 4'b1011, 1'b0, 4'b1000, 1'b0, 8'hA5); // 21 from last=2 search starts at 3
    add(1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 8'h3C); // 22 last=3
    add(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0, 8'h3C); // 23 wrap path regrants 3
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h3C); // 24
    add(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0, 8'h3C); // 25 grant, next cycle is WRITE
    add(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h3C); // 26 reset during WRITE
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 8'h00); // 27 write abandoned, requester 0 first
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h5A); // 28
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h5A); // 29 last=0
    add(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 8'h5A); // 30 req 2 blocked by full
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 8'h5A); // 31 req 2 dropped, 1 wins
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h11); // 32

    repeat (2) @(posedge wr_clk);

    foreach (vecs[i]) begin
      #1;
      res  = vecs[i].res;
      req  = vecs[i].req;
      full = vecs[i].full;
      @(negedge wr_clk);
      chk("gnt",   i, {12'h0, gnt},   {12'h0, vecs[i].gnt});
      chk("wr_en", i, {15'h0, wr_en}, {15'h0, vecs[i].wr_en});
      chk("wdata", i, {8'h0, wdata},  {8'h0, vecs[i].wdata});
      $display("row %0d: res=%b req=%b full=%b gnt=%b wr_en=%b wdata=%h",
               i, res, req, full, gnt, wr_en, wdata);
      @(posedge wr_clk);
    end

    // Throughput: with every requester asserted, 8 cycles yield exactly 4 writes.
    #1;
    res = 1'b0; req = 4'b1111; full = 1'b0;
    wr_count = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge wr_clk);
      if (wr_en) wr_count++;
      chk("gnt_onehot0", 100 + c, {15'h0, $onehot0(gnt)}, 16'h0001);
      @(posedge wr_clk);
    end
    chk("throughput", 108, 16'(wr_count), 16'd4);
    $display("throughput: %0d writes in 8 cycles", wr_count);
    #1;
    req = 4'b0000;

`ifdef WR_ARB_OVF_CNT_EN
    // Three overflow pulses, then a long run that must saturate.
    overflow = 1'b1;
    repeat (3) @(posedge wr_clk);
    #1 overflow = 1'b0;
    @(negedge wr_clk);
    chk("ovf_cnt_3", 200, ovf_cnt, 16'd3);
    $display("ovf_cnt after 3 pulses: %0d", ovf_cnt);
    @(posedge wr_clk);
    #1 overflow = 1'b1;
    repeat (70000) @(posedge wr_clk);
    #1 overflow = 1'b0;
    @(negedge wr_clk);
    chk("ovf_cnt_sat", 201, ovf_cnt, 16'hFFFF);
    $display("ovf_cnt after 70003 pulses: %h", ovf_cnt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
